// File: rtl/bin_to_bcd_seq.sv
// Sequential 27-bit binary to 8-digit packed BCD converter (double dabble).
// Optional leading-zero blank mask via macro BCD_LEADING_BLANK_EN.
module bin_to_bcd_seq (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [26:0] i_bin_in,
  output logic [31:0] o_bcd_out,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow,
  output logic [7:0]  o_blank
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam logic [26:0] MAX_DEC = 27'd99_999_999;
  localparam logic [31:0] SAT_BCD = 32'h9999_9999;

  state_t      r_state;
  logic [31:0] r_bcd;
  logic [26:0] r_bin;
  logic [4:0]  r_cnt;
  logic        r_ovf;
  logic [31:0] r_bcd_out;
  logic        r_busy;
  logic        r_done;
  logic        r_overflow;
  logic [7:0]  r_blank;

  logic [31:0] w_bcd_adj;
  logic [58:0] w_work_next;
  logic [31:0] w_result;
  logic [7:0]  w_blank;

  // Add-3 correction on every BCD nibble that will overflow when doubled.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 8; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_work_next = {w_bcd_adj, r_bin} << 1;

  // The overflow flag is latched at capture because the operand is
  // shifted out of the working register during conversion.
  assign w_result = r_ovf ? SAT_BCD : r_bcd;

`ifdef BCD_LEADING_BLANK_EN
  logic w_lead_zero;

  // Bit i is set while every digit from 7 down to i is zero; digit 0 is
  // never blanked so a zero result still shows one digit.
  always_comb begin
    w_blank     = 8'h00;
    w_lead_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      w_lead_zero = w_lead_zero & (w_result[4*i +: 4] == 4'h0);
      w_blank[i]  = w_lead_zero;
    end
  end
`else
  assign w_blank = 8'h00;
`endif

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_bcd      <= '0;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_bcd_out  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_blank    <= 8'h00;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bin   <= i_bin_in;
            r_bcd   <= '0;
            r_cnt   <= 5'd27;
            r_ovf   <= (i_bin_in > MAX_DEC);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_work_next[58:27];
          r_bin <= w_work_next[26:0];
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_bcd_out  <= w_result;
          r_overflow <= r_ovf;
          r_blank    <= w_blank;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_bcd_out  = r_bcd_out;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_blank    = r_blank;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: decimal reference model with per-cycle
// comparison plus directed literal checks.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [26:0] bin_in;
  logic [31:0] o_bcd_out;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [7:0]  o_blank;

  int tests = 0;
  int fails = 0;

  bin_to_bcd_seq dut (
    .i_clock   (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_bin_in  (bin_in),
    .o_bcd_out (o_bcd_out),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_overflow(o_overflow),
    .o_blank   (o_blank)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dec_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    if (v > 99_999_999) return 32'h9999_9999;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] blank_of(input int unsigned v);
`ifdef BCD_LEADING_BLANK_EN
    int unsigned t;
    int n;
    logic [7:0] m;
    t = (v > 99_999_999) ? 99_999_999 : v;
    n = 1;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    m = 8'hFF;
    return m << n;
`else
    return (v > 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference model state, advanced once per rising edge.
  bit          m_active = 0;
  int          m_start  = 0;
  int unsigned m_val    = 0;
  int          cyc      = 0;
  bit          chk_en   = 0;
  logic [31:0] e_bcd    = '0;
  logic        e_ovf    = 1'b0;
  logic        e_done   = 1'b0;
  logic        e_busy   = 1'b0;
  logic [7:0]  e_blank  = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      e_done = 1'b0;
      if (reset) begin
        m_active = 0;
        e_bcd    = '0;
        e_ovf    = 1'b0;
        e_blank  = 8'h00;
      end else if (m_active) begin
        if (cyc == m_start + 28) begin
          e_bcd    = dec_bcd(m_val);
          e_ovf    = (m_val > 99_999_999);
          e_blank  = blank_of(m_val);
          e_done   = 1'b1;
          m_active = 0;
        end
      end else if (start) begin
        m_active = 1;
        m_start  = cyc;
        m_val    = int'(bin_in);
      end
      e_busy = m_active;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        tests++;
        if ({o_done, o_busy, o_overflow, o_bcd_out, o_blank} !==
            {e_done, e_busy, e_ovf, e_bcd, e_blank}) begin
          fails++;
          $display("FAIL cycle %0d: d/b/o/bcd/blk got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                   cyc, o_done, o_busy, o_overflow, o_bcd_out, o_blank,
                   e_done, e_busy, e_ovf, e_bcd, e_blank);
        end
      end
    end
  end

  task automatic convert(input int unsigned v);
    int lat;
    start  = 1'b1;
    bin_in = 27'(v);
    lat    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_done) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'd29);
  endtask

  initial begin
    int ndone;
    int unsigned v;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_bcd", o_bcd_out, 32'h0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_blank", 32'(o_blank), 32'h0);
    check("rst_ovf", 32'(o_overflow), 32'd0);

    start  = 1'b1;
    bin_in = 27'd5;
    @(negedge clk);
    check("rst_prio_busy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    convert(12_345_678);
    check("bcd_12345678", o_bcd_out, 32'h1234_5678);
    check("ovf_12345678", 32'(o_overflow), 32'd0);
    check("blank_12345678", 32'(o_blank), 32'h00);

    convert(0);
    check("bcd_zero", o_bcd_out, 32'h0);
`ifdef BCD_LEADING_BLANK_EN
    check("blank_zero", 32'(o_blank), 32'hFE);
`else
    check("blank_zero", 32'(o_blank), 32'h00);
`endif

    convert(32'h07FF_FFFF);
    check("bcd_sat", o_bcd_out, 32'h9999_9999);
    check("ovf_sat", 32'(o_overflow), 32'd1);
    convert(99_999_999);
    check("bcd_max", o_bcd_out, 32'h9999_9999);
    check("ovf_max", 32'(o_overflow), 32'd0);

    start  = 1'b1;
    bin_in = 27'd305;
    ndone  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) begin
        start  = 1'b1;
        bin_in = 27'd7;
      end
      if (k == 11) start = 1'b0;
      if (k == 20) check("hold_bcd", o_bcd_out, 32'h9999_9999);
      if (o_done) begin
        ndone++;
        break;
      end
    end
    check("bcd_305", o_bcd_out, 32'h0000_0305);
`ifdef BCD_LEADING_BLANK_EN
    check("blank_305", 32'(o_blank), 32'hF8);
`else
    check("blank_305", 32'(o_blank), 32'h00);
`endif
    repeat (40) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    check("ignored_start_dones", 32'(ndone), 32'd1);

    start  = 1'b1;
    bin_in = 27'd42;
    ndone  = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 15) reset = 1'b1;
      if (k == 16) begin
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_bcd", o_bcd_out, 32'h0);
        reset = 1'b0;
      end
      if (o_done) ndone++;
    end
    check("abort_dones", 32'(ndone), 32'd0);
    convert(42);
    check("bcd_42", o_bcd_out, 32'h0000_0042);

    for (int n = 0; n < 1000; n++) begin
      v = $urandom_range(99_999_999, 0);
      convert(v);
    end

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  conversion request, sampled on the rising edge of clock.
REQ-005 bin_in  input  27  unsigned binary operand, captured on an accepted start.
REQ-006 bcd_out  output  32  eight packed BCD digits; digit 0 (least significant) in [3:0], digit 7 in [31:28]; feeds the display mux HEX input directly.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when bcd_out has been updated.
REQ-009 overflow  output  1  high when the last captured operand exceeded 99_999_999.
REQ-010 blank  output  8  per-digit leading-zero mask; bit i=1 means digit i is a leading zero (see Configuration).

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and FINISH, and SHALL use the iterative shift-add-3 (double-dabble) algorithm with one shift per clock.
REQ-012 IDLE: when start=1, the block SHALL capture bin_in into the shift register, clear the 32-bit BCD working register, load the iteration counter with 27, and go to SHIFT; otherwise it SHALL stay in IDLE.
REQ-013 SHIFT, each cycle: every working BCD nibble >= 5 SHALL have 3 added, then the combined {BCD, binary} register SHALL shift left by 1 and the counter SHALL decrement; after the 27th shift the FSM SHALL go to FINISH.
REQ-014 FINISH: bcd_out, overflow and blank SHALL be registered from the working result, done SHALL be 1 for exactly this cycle, and the FSM SHALL return to IDLE.
REQ-015 Latency: done SHALL be high in the cycle beginning 28 rising edges after the edge that sampled start; busy SHALL be high for the 27 SHIFT cycles and the FINISH cycle.
REQ-016 A start asserted while busy=1 SHALL be ignored, not queued; a start sampled in the cycle after FINISH SHALL begin a new conversion.
REQ-017 bcd_out SHALL hold its previous value during a conversion and SHALL never show intermediate working values.
REQ-018 If the captured bin_in > 99_999_999, bcd_out SHALL saturate to 32'h9999_9999 and overflow SHALL be 1; otherwise overflow SHALL be 0. overflow SHALL update only in FINISH.
REQ-019 The conversion SHALL be correct for all captured values 0..99_999_999, including 0 and 99_999_999.

Reset
REQ-020 With reset=1 at a rising edge, the block SHALL go to IDLE with bcd_out=0, done=0, busy=0, overflow=0, blank=8'h00, working registers=0.
REQ-021 Reset during SHIFT SHALL abort the conversion; no done pulse SHALL follow, and bcd_out SHALL read 0.
REQ-022 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-023 Macro BCD_LEADING_BLANK_EN: when defined, blank SHALL be computed in FINISH, with bit i=1 iff digits 7..i of the result are all zero; bit 0 SHALL always be 0, so a result of 0 gives blank=8'hFE.
REQ-024 When BCD_LEADING_BLANK_EN is undefined, blank SHALL be tied to 8'h00, no blanking logic SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-025 Reset, then pulse start with bin_in=12_345_678 -> done at start-edge+28, bcd_out=32'h1234_5678, overflow=0; blank=8'h00 with or without the macro.
REQ-026 Pulse start with bin_in=0, macro defined -> bcd_out=32'h0000_0000, blank=8'hFE; macro undefined -> blank=8'h00.
REQ-027 Pulse start with bin_in=27'h7FF_FFFF (134_217_727) -> bcd_out=32'h9999_9999, overflow=1; then convert 99_999_999 -> bcd_out=32'h9999_9999, overflow=0.
REQ-028 Pulse start with bin_in=305 (macro defined), re-assert start at cycle 10 with bin_in=7 -> exactly one done, bcd_out=32'h0000_0305, blank=8'hF8; bcd_out stays unchanged before done.
REQ-029 Assert reset at cycle 15 of a conversion of 42 -> no done, busy=0 and bcd_out=0 next cycle; a following start with bin_in=42 -> bcd_out=32'h0000_0042.
REQ-030 Random sweep of 1_000 values in 0..99_999_999, each back-to-back with the previous done -> every bcd_out matches the golden decimal model, with a 29-cycle period per result.
